// File: rtl/fpu_issue_ctl.sv
// FPU issue controller: accepts one op at a time, times its fixed latency and stalls decode.
// Optional `FPU_RAW_CHECK_EN` enables per-register RAW hazard checking instead of full blocking.
module fpu_issue_ctl #(
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 8,
    parameter int LAT_SQRT = 8,
    parameter int LAT_MISC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       use_fpu,
    input  logic [4:0] ctl,
    input  logic       writef,
    input  logic [4:0] write_reg,
    input  logic       readf1,
    input  logic       readf2,
    input  logic       read_reg1,
    input  logic       read_reg2,
    input  logic [4:0] reg1_addr,
    input  logic [4:0] reg2_addr,
    input  logic       flush,
    output logic       fpu_start,
    output logic [4:0] fpu_ctl,
    output logic       stall,
    output logic       busy,
    output logic       wb_valid,
    output logic [4:0] wb_reg,
    output logic       wb_float
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state, state_nx;
    logic [4:0] cnt, cnt_nx;
    logic [4:0] pend_reg;
    logic       pend_writef;
    logic [4:0] lat;
    logic       hazard;
    logic       accept;

    always_comb begin
        case (ctl)
            5'd0, 5'd1: lat = 5'(LAT_ADD);
            5'd2:       lat = 5'(LAT_MUL);
            5'd4:       lat = 5'(LAT_DIV);
            5'd19:      lat = 5'(LAT_SQRT);
            default:    lat = 5'(LAT_MISC);
        endcase
    end

`ifdef FPU_RAW_CHECK_EN
    logic src1_hit, src2_hit;

    // x0 is hard-wired zero, so an integer write to it can never create a dependency.
    assign src1_hit = pend_writef ? (readf1 && reg1_addr == pend_reg)
                                  : (read_reg1 && reg1_addr == pend_reg && reg1_addr != 5'd0);
    assign src2_hit = pend_writef ? (readf2 && reg2_addr == pend_reg)
                                  : (read_reg2 && reg2_addr == pend_reg && reg2_addr != 5'd0);
    assign hazard   = src1_hit || src2_hit;
`else
    logic unused_src_info;

    assign unused_src_info = ^{readf1, readf2, read_reg1, read_reg2, reg1_addr, reg2_addr};
    assign hazard          = 1'b1;
`endif

    // DONE never stalls: the register files forward the same-cycle writeback.
    assign stall  = in_valid && (state == BUSY) && (use_fpu || hazard);
    assign accept = in_valid && use_fpu && !flush && !stall && (state == IDLE || state == DONE);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            BUSY: begin
                cnt_nx = cnt - 5'd1;
                if (cnt == 5'd1) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = state;
        endcase
        if (accept) begin
            state_nx = (lat == 5'd1) ? DONE : BUSY;
            cnt_nx   = lat - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            pend_reg    <= 5'd0;
            pend_writef <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                pend_reg    <= write_reg;
                pend_writef <= writef;
            end
        end
    end

    assign fpu_start = accept;
    assign fpu_ctl   = accept ? ctl : 5'd0;
    assign busy      = (state != IDLE);
    assign wb_valid  = (state == DONE);
    assign wb_reg    = wb_valid ? pend_reg : 5'd0;
    assign wb_float  = wb_valid && pend_writef;

endmodule

// File: doc/fpu_issue_ctl.md
# fpu_issue_ctl

Issue controller for the floating-point unit. It sits in the execute stage, behind the registered decode outputs. It accepts one FPU operation at a time, times its fixed latency with a down-counter and raises `stall` back to the decode stage while a later instruction must wait. When the result is due it emits a one-cycle writeback strobe carrying the destination register.

## Interface
Parameters:
- `LAT_ADD`, 3: cycles for ctl 0/1 (fadd, fsub).
- `LAT_MUL`, 2: cycles for ctl 2 (fmul).
- `LAT_DIV`, 8: cycles for ctl 4 (fdiv).
- `LAT_SQRT`, 8: cycles for ctl 19 (fsqrt).
- `LAT_MISC`, 1: cycles for every other ctl.
- All latencies must be in the range 1..31.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: EX-stage instruction present (not a bubble).
- `use_fpu` in 1: instruction is an FPU op.
- `ctl` in 5: FPU op code.
- `writef` in 1: destination is the FP register file.
- `write_reg` in 5: destination register.
- `readf1`, `readf2` in 1: source 1/2 read the FP file.
- `read_reg1`, `read_reg2` in 1: source 1/2 read the integer file.
- `reg1_addr`, `reg2_addr` in 5: source register addresses.
- `flush` in 1: branch mispredict this cycle (branch_wrong).
- `fpu_start` out 1: launch pulse to the FPU (combinational).
- `fpu_ctl` out 5: op code to the FPU; equals `ctl` when `fpu_start` is high, otherwise 0.
- `stall` out 1: hold decode/EX (combinational).
- `busy` out 1: state is not IDLE.
- `wb_valid` out 1: result writeback strobe.
- `wb_reg` out 5: writeback destination.
- `wb_float` out 1: writeback targets the FP file.

## Operation
- States: IDLE, BUSY, DONE.
- `accept` = `in_valid & use_fpu & ~flush & ~stall & (state==IDLE | state==DONE)`.
- `fpu_start` = `accept`.
- LAT is selected from `ctl` at accept.
- On accept, the block latches `pend_reg`←`write_reg` and `pend_writef`←`writef`.
- On accept with LAT==1, the next state is DONE.
- On accept with LAT≥2, the next state is BUSY and `cnt`←LAT−1.
- In BUSY, `cnt` decrements every cycle. When `cnt==1`, the next state is DONE.
- DONE:
  - `wb_valid`=1, `wb_reg`=`pend_reg`, `wb_float`=`pend_writef`.
  - Next state is BUSY or DONE if a new op is accepted in this cycle, otherwise IDLE.
  - `pend_*` is overwritten only after the current writeback is driven.
- `stall` = `in_valid & state==BUSY & (use_fpu | hazard)`.
- DONE never stalls: the register files forward same-cycle writes.
- Hazard for a source: it reads the pending file (FP if `pend_writef`, else integer), its address equals `pend_reg`, and it is not the integer register x0.
- `flush` only blocks acceptance in the current cycle. An op already in flight is older than the branch and always completes.
- `wb_reg` and `wb_float` are 0 whenever `wb_valid` is 0.

## Timing
- Reset:
  - state=IDLE, `cnt`=0, `pend_reg`=0, `pend_writef`=0.
  - All outputs are 0 (`stall`=0 because state is IDLE).
- Reset mid-operation drops the in-flight op; no writeback is issued.
- Latency: an op accepted in cycle T has `wb_valid` in cycle T+LAT exactly.
- Back-to-back: a new FPU op may be accepted in the DONE cycle of the previous op. This gives a throughput of one op per LAT cycles.
- While stalled, the inputs hold stable (decode holds). Acceptance happens in the first non-BUSY cycle.
- Simultaneous `flush` and `use_fpu` in IDLE: no accept, no state change.
- Simultaneous `flush` in DONE: the writeback still occurs and the next state is IDLE.

## Configuration
- Macro `FPU_RAW_CHECK_EN`.
- Defined: `hazard` is computed as described in Operation. Non-FPU instructions independent of `pend_reg` proceed while BUSY.
- Undefined: `hazard` is tied to 1. Every valid instruction stalls while BUSY, which gives in-order full blocking.
- Acceptance, latency and writeback timing are identical in both builds.

## Test plan
- fadd after reset: `ctl`=0, `write_reg`=5, `writef`=1, accepted at T → `fpu_start` high at T only; `busy` high T+1..T+3; `wb_valid`=1 with `wb_reg`=5 and `wb_float`=1 at T+3 only.
- fdiv (`ctl`=4) at T, followed by fmul (`ctl`=2) presented at T+1 → `stall`=1 for T+1..T+7; fmul accepted at T+8 (the DONE cycle of fdiv); fmul `wb_valid` at T+10.
- With `FPU_RAW_CHECK_EN`: fsqrt writes f3; next an integer add with `read_reg1`=1 and `reg1_addr`=3 → no stall. Then an op with `readf1`=1 and `reg1_addr`=3 → stalls until the DONE cycle.
- Same sequence without the macro → the integer add stalls through all BUSY cycles.
- `flush`=1 with an FPU op in IDLE → no `fpu_start`, `busy` stays 0. `flush` during fdiv BUSY → writeback still at T+8.
- `rst` asserted at T+2 of an fdiv → next cycle: state IDLE, all outputs 0, and no `wb_valid` ever appears for that op.
- LAT_MISC op (`ctl`=12, fneg) at T → `wb_valid` at T+1. A second fneg accepted at T+1 → `wb_valid` at T+2 with no stall.
